// File: rtl/csr_access_unit.sv
// Machine-mode Zicsr access sequencer: IDLE -> EVAL -> (WRITE) -> RESP, one instruction at a time.
// Optional local 64-bit mcycle counter at 0xB00/0xB80 is built only when CSR_MCYCLE_EN is defined.
module csr_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [4:0]      req_rs1,
    input  logic [XLEN-1:0] req_rs1_val,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal,
    input  logic [1:0]      misa_MXL_i,
    input  logic [25:0]     misa_ext_i,
    input  logic [XLEN-1:0] mvendorid_i,
    input  logic [XLEN-1:0] marchid_i,
    input  logic [XLEN-1:0] mimpid_i,
    input  logic [XLEN-1:0] mhartid_i,
    input  logic [XLEN-1:0] mstatus_i,
    output logic            misa_EN,
    output logic [127:0]    misa_d,
    output logic            mstatus_EN,
    output logic [31:0]     mstatus_d
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        TGT_NONE      = 3'd0,
        TGT_MISA      = 3'd1,
        TGT_MSTATUS   = 3'd2,
        TGT_MSCRATCH  = 3'd3,
        TGT_MCYCLE_LO = 3'd4,
        TGT_MCYCLE_HI = 3'd5
    } tgt_t;

    state_t          state_r, state_s;
    tgt_t            tgt_r, tgt_s;
    logic [2:0]      funct3_r;
    logic [11:0]     addr_r;
    logic [4:0]      rs1_r;
    logic [XLEN-1:0] rs1_val_r;
    logic [XLEN-1:0] rdata_r;
    logic            illegal_r;
    logic [XLEN-1:0] wdata_r;
    logic [XLEN-1:0] mscratch_r;
    logic [XLEN-1:0] src_s, old_s, new_s;
    logic            mapped_s, wint_s, illegal_s;
`ifdef CSR_MCYCLE_EN
    logic [63:0]     mcycle_r;
`endif

    // Status outputs decode directly from the state register so a reset drops them at once.
    assign req_ready   = (state_r == ST_IDLE);
    assign rsp_valid   = (state_r == ST_RESP);
    assign rsp_rdata   = rdata_r;
    assign rsp_illegal = illegal_r;
    assign misa_EN     = (state_r == ST_WRITE) && (tgt_r == TGT_MISA);
    assign mstatus_EN  = (state_r == ST_WRITE) && (tgt_r == TGT_MSTATUS);
    assign misa_d      = {wdata_r[31:30], 72'd0, 28'd0, wdata_r[25:0]};
    assign mstatus_d   = wdata_r[31:0];

    // Decode the captured instruction: source operand, old value, new value, legality.
    always_comb begin
        src_s    = funct3_r[2] ? {{(XLEN-5){1'b0}}, rs1_r} : rs1_val_r;
        wint_s   = (funct3_r[1:0] == 2'b01) || (rs1_r != 5'd0);
        old_s    = '0;
        mapped_s = 1'b1;
        tgt_s    = TGT_NONE;
        case (addr_r)
            12'h300: begin old_s = mstatus_i;  tgt_s = TGT_MSTATUS;  end
            12'h301: begin old_s = XLEN'({misa_MXL_i, 4'b0000, misa_ext_i}); tgt_s = TGT_MISA; end
            12'h340: begin old_s = mscratch_r; tgt_s = TGT_MSCRATCH; end
            12'hF11: old_s = mvendorid_i;
            12'hF12: old_s = marchid_i;
            12'hF13: old_s = mimpid_i;
            12'hF14: old_s = mhartid_i;
`ifdef CSR_MCYCLE_EN
            12'hB00: begin old_s = mcycle_r[31:0];  tgt_s = TGT_MCYCLE_LO; end
            12'hB80: begin old_s = mcycle_r[63:32]; tgt_s = TGT_MCYCLE_HI; end
`endif
            default: mapped_s = 1'b0;
        endcase
        case (funct3_r[1:0])
            2'b01:   new_s = src_s;
            2'b10:   new_s = old_s | src_s;
            2'b11:   new_s = old_s & ~src_s;
            default: new_s = src_s;
        endcase
        illegal_s = (funct3_r[1:0] == 2'b00) || !mapped_s ||
                    (wint_s && (addr_r[11:10] == 2'b11));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_s = ST_EVAL;
                else           state_s = ST_IDLE;
            end
            ST_EVAL: begin
                if (illegal_s || !wint_s) state_s = ST_RESP;
                else                      state_s = ST_WRITE;
            end
            ST_WRITE: state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_s = ST_IDLE;
                else           state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Request capture, EVAL result latching and the local mscratch.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            funct3_r   <= 3'd0;
            addr_r     <= 12'd0;
            rs1_r      <= 5'd0;
            rs1_val_r  <= '0;
            rdata_r    <= '0;
            illegal_r  <= 1'b0;
            wdata_r    <= '0;
            tgt_r      <= TGT_NONE;
            mscratch_r <= '0;
        end else begin
            if ((state_r == ST_IDLE) && req_valid) begin
                funct3_r  <= req_funct3;
                addr_r    <= req_addr;
                rs1_r     <= req_rs1;
                rs1_val_r <= req_rs1_val;
            end
            if (state_r == ST_EVAL) begin
                rdata_r   <= illegal_s ? '0 : old_s;
                illegal_r <= illegal_s;
                wdata_r   <= new_s;
                tgt_r     <= (illegal_s || !wint_s) ? TGT_NONE : tgt_s;
            end
            if ((state_r == ST_WRITE) && (tgt_r == TGT_MSCRATCH)) begin
                mscratch_r <= wdata_r;
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    // Free-running cycle counter; a write to one half replaces the increment for that cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mcycle_r <= 64'd0;
        end else if ((state_r == ST_WRITE) && (tgt_r == TGT_MCYCLE_LO)) begin
            mcycle_r <= {mcycle_r[63:32], wdata_r[31:0]};
        end else if ((state_r == ST_WRITE) && (tgt_r == TGT_MCYCLE_HI)) begin
            mcycle_r <= {wdata_r[31:0], mcycle_r[31:0]};
        end else begin
            mcycle_r <= mcycle_r + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: directed table, hand sequences and random ops vs a reference model.
module tb_csr_access_unit;

    logic         CLK = 1'b0;
    logic         RSTn;
    logic         req_valid, req_ready;
    logic [2:0]   req_funct3;
    logic [11:0]  req_addr;
    logic [4:0]   req_rs1;
    logic [31:0]  req_rs1_val;
    logic         rsp_valid, rsp_ready;
    logic [31:0]  rsp_rdata;
    logic         rsp_illegal;
    logic [1:0]   misa_MXL_i;
    logic [25:0]  misa_ext_i;
    logic [31:0]  mvendorid_i, marchid_i, mimpid_i, mhartid_i, mstatus_i;
    logic         misa_EN, mstatus_EN;
    logic [127:0] misa_d;
    logic [31:0]  mstatus_d;

    int checks = 0;
    int failures = 0;
    logic [31:0] mscratch_m;

    csr_access_unit #(.XLEN(32)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_rs1(req_rs1), .req_rs1_val(req_rs1_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_illegal(rsp_illegal), .misa_MXL_i(misa_MXL_i), .misa_ext_i(misa_ext_i),
        .mvendorid_i(mvendorid_i), .marchid_i(marchid_i), .mimpid_i(mimpid_i),
        .mhartid_i(mhartid_i), .mstatus_i(mstatus_i),
        .misa_EN(misa_EN), .misa_d(misa_d), .mstatus_EN(mstatus_EN), .mstatus_d(mstatus_d)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] repack(input logic [31:0] w);
        return {w[31:30], 100'd0, w[25:0]};
    endfunction

    // Reference: decoded from the architectural rules; tgt 1=misa 2=mstatus 3=mscratch.
    task automatic model(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                         input logic [31:0] rv, output logic [31:0] e_rd, output logic e_il,
                         output int e_cyc, output int tgt, output logic [31:0] nv);
        logic [31:0] src, old;
        logic mapped, wint;
        src = f3[2] ? {27'd0, r1} : rv;
        mapped = 1'b1;
        tgt = 0;
        old = 32'd0;
        if (a == 12'h300) begin old = mstatus_i; tgt = 2; end
        else if (a == 12'h301) begin old = {misa_MXL_i, 4'd0, misa_ext_i}; tgt = 1; end
        else if (a == 12'h340) begin old = mscratch_m; tgt = 3; end
        else if (a == 12'hF11) old = mvendorid_i;
        else if (a == 12'hF12) old = marchid_i;
        else if (a == 12'hF13) old = mimpid_i;
        else if (a == 12'hF14) old = mhartid_i;
        else mapped = 1'b0;
        wint = (f3 == 3'b001) || (f3 == 3'b101) || (r1 != 5'd0);
        if (f3 == 3'b001 || f3 == 3'b101) nv = src;
        else if (f3 == 3'b010 || f3 == 3'b110) nv = old | src;
        else nv = old & ~src;
        e_il = (f3 == 3'b000) || (f3 == 3'b100) || !mapped || (wint && a[11:10] == 2'b11);
        e_rd = e_il ? 32'd0 : old;
        if (e_il || !wint) tgt = 0;
        e_cyc = (tgt != 0) ? 3 : 2;
    endtask

    task automatic do_op(input string nm, input logic [2:0] f3, input logic [11:0] a,
                         input logic [4:0] r1, input logic [31:0] rv, input int hold,
                         output logic [31:0] rd, output logic il, output int cyc,
                         output int n_misa, output int n_mst,
                         output logic [127:0] md, output logic [31:0] sd);
        n_misa = 0; n_mst = 0; md = 128'd0; sd = 32'd0;
        @(negedge CLK);
        chk({nm, "_req_ready"}, req_ready, 1'b1);
        req_funct3 = f3; req_addr = a; req_rs1 = r1; req_rs1_val = rv; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 12) begin
            if (misa_EN) begin n_misa++; md = misa_d; end
            if (mstatus_EN) begin n_mst++; sd = mstatus_d; end
            @(posedge CLK); #1;
            cyc++;
        end
        if (!rsp_valid) chk({nm, "_rsp_timeout"}, 1'b0, 1'b1);
        rd = rsp_rdata;
        il = rsp_illegal;
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            chk({nm, "_hold_valid"}, rsp_valid, 1'b1);
            chk({nm, "_hold_rdata"}, rsp_rdata, rd);
            chk({nm, "_hold_illegal"}, rsp_illegal, il);
            chk({nm, "_hold_req_ready"}, req_ready, 1'b0);
            chk({nm, "_hold_en"}, {misa_EN, mstatus_EN}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        chk({nm, "_done_valid"}, rsp_valid, 1'b0);
        chk({nm, "_done_req_ready"}, req_ready, 1'b1);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1;
        logic [31:0] rv;
        logic [31:0] mst;
        int          hold;
        logic [31:0] e_rd;
        logic        e_il;
        int          e_cyc;
        int          e_nmisa;
        int          e_nmst;
        logic [31:0] e_d;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0] rd, e_rd, nv, h0;
        logic [127:0] md;
        logic [31:0] sd;
        logic il, e_il;
        int cyc, nmisa, nmst, e_cyc, tgt;

        tbl[0]  = '{3'b001, 12'h340, 5'd5,  32'hDEADBEEF, 32'h0,  0, 32'h0,        1'b0, 3, 0, 0, 32'h0};
        tbl[1]  = '{3'b010, 12'h340, 5'd0,  32'h0,        32'h0,  0, 32'hDEADBEEF, 1'b0, 2, 0, 0, 32'h0};
        tbl[2]  = '{3'b111, 12'h300, 5'd8,  32'h0,        32'h88, 0, 32'h88,       1'b0, 3, 0, 1, 32'h80};
        tbl[3]  = '{3'b001, 12'hF14, 5'd3,  32'h1234,     32'h0,  0, 32'h0,        1'b1, 2, 0, 0, 32'h0};
        tbl[4]  = '{3'b010, 12'hF14, 5'd0,  32'h0,        32'h0,  0, 32'h0,        1'b0, 2, 0, 0, 32'h0};
        tbl[5]  = '{3'b100, 12'h300, 5'd1,  32'h0,        32'h88, 4, 32'h0,        1'b1, 2, 0, 0, 32'h0};
        tbl[6]  = '{3'b010, 12'h7C0, 5'd0,  32'h0,        32'h0,  4, 32'h0,        1'b1, 2, 0, 0, 32'h0};
        tbl[7]  = '{3'b010, 12'h301, 5'd0,  32'h0,        32'h0,  0, 32'h40000104, 1'b0, 2, 0, 0, 32'h0};
        tbl[8]  = '{3'b001, 12'h301, 5'd1,  32'h80000005, 32'h0,  0, 32'h40000104, 1'b0, 3, 1, 0, 32'h80000005};
        tbl[9]  = '{3'b110, 12'hF11, 5'd0,  32'h0,        32'h0,  0, 32'h612,      1'b0, 2, 0, 0, 32'h0};
        tbl[10] = '{3'b110, 12'hF11, 5'd1,  32'h0,        32'h0,  0, 32'h0,        1'b1, 2, 0, 0, 32'h0};
        tbl[11] = '{3'b011, 12'h340, 5'd2,  32'h000000FF, 32'h0,  1, 32'hDEADBEEF, 1'b0, 3, 0, 0, 32'h0};
        tbl[12] = '{3'b110, 12'h340, 5'd0,  32'h0,        32'h0,  0, 32'hDEADBE00, 1'b0, 2, 0, 0, 32'h0};
        tbl[13] = '{3'b101, 12'h300, 5'd31, 32'hFFFFFFFF, 32'h88, 0, 32'h88,       1'b0, 3, 0, 1, 32'h1F};
        tbl[14] = '{3'b000, 12'h340, 5'd0,  32'h0,        32'h0,  0, 32'h0,        1'b1, 2, 0, 0, 32'h0};

        RSTn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_funct3 = 3'd0; req_addr = 12'd0; req_rs1 = 5'd0; req_rs1_val = 32'd0;
        misa_MXL_i = 2'b01; misa_ext_i = 26'h0000104;
        mvendorid_i = 32'h612; marchid_i = 32'h2A; mimpid_i = 32'h1; mhartid_i = 32'h0;
        mstatus_i = 32'h0;
        mscratch_m = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_illegal", rsp_illegal, 1'b0);
        chk("reset_en", {misa_EN, mstatus_EN}, 2'b00);
        chk("reset_misa_d", misa_d, 128'd0);
        chk("reset_mstatus_d", mstatus_d, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            mstatus_i = tbl[i].mst;
            do_op($sformatf("tbl%0d", i), tbl[i].f3, tbl[i].addr, tbl[i].rs1, tbl[i].rv,
                  tbl[i].hold, rd, il, cyc, nmisa, nmst, md, sd);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_illegal", i), il, tbl[i].e_il);
            chk($sformatf("tbl%0d_latency", i), cyc, tbl[i].e_cyc);
            chk($sformatf("tbl%0d_misa_en", i), nmisa, tbl[i].e_nmisa);
            chk($sformatf("tbl%0d_mstatus_en", i), nmst, tbl[i].e_nmst);
            if (tbl[i].e_nmst != 0) chk($sformatf("tbl%0d_mstatus_d", i), sd, tbl[i].e_d);
            if (tbl[i].e_nmisa != 0) chk($sformatf("tbl%0d_misa_d", i), md, repack(tbl[i].e_d));
        end
        mscratch_m = 32'hDEADBE00;

        // Reset asserted while the mstatus write strobe is high.
        @(negedge CLK);
        req_funct3 = 3'b001; req_addr = 12'h300; req_rs1 = 5'd1; req_rs1_val = 32'h1234;
        req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        chk("rst_mid_en_before", mstatus_EN, 1'b1);
        RSTn = 1'b0;
        #1;
        chk("rst_mid_en_after", mstatus_EN, 1'b0);
        chk("rst_mid_req_ready", req_ready, 1'b1);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        @(negedge CLK);
        RSTn = 1'b1;
        mscratch_m = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            chk("rst_mid_no_rsp", rsp_valid, 1'b0);
            chk("rst_mid_no_en", mstatus_EN, 1'b0);
        end
        do_op("rst_mscratch", 3'b010, 12'h340, 5'd0, 32'd0, 0, rd, il, cyc, nmisa, nmst, md, sd);
        chk("rst_mscratch_rdata", rd, 32'd0);

`ifdef CSR_MCYCLE_EN
        do_op("mcyc_rd_hi0", 3'b010, 12'hB80, 5'd0, 32'd0, 0, h0, il, cyc, nmisa, nmst, md, sd);
        chk("mcyc_rd_hi0_illegal", il, 1'b0);
        do_op("mcyc_wr_lo", 3'b001, 12'hB00, 5'd1, 32'hFFFFFFFF, 0, rd, il, cyc, nmisa, nmst, md, sd);
        chk("mcyc_wr_lo_illegal", il, 1'b0);
        chk("mcyc_wr_lo_latency", cyc, 3);
        chk("mcyc_wr_lo_no_bank_en", nmisa + nmst, 0);
        repeat (3) @(posedge CLK);
        do_op("mcyc_rd_hi1", 3'b010, 12'hB80, 5'd0, 32'd0, 0, rd, il, cyc, nmisa, nmst, md, sd);
        chk("mcyc_carry_hi", rd, h0 + 32'd1);
        do_op("mcyc_rd_lo", 3'b010, 12'hB00, 5'd0, 32'd0, 0, rd, il, cyc, nmisa, nmst, md, sd);
        chk("mcyc_lo_wrapped_small", rd < 32'd64, 1'b1);
`else
        do_op("mcyc_wr_lo", 3'b001, 12'hB00, 5'd1, 32'hFFFFFFFF, 0, rd, il, cyc, nmisa, nmst, md, sd);
        chk("mcyc_lo_illegal", il, 1'b1);
        chk("mcyc_lo_rdata", rd, 32'd0);
        do_op("mcyc_rd_hi", 3'b010, 12'hB80, 5'd0, 32'd0, 0, rd, il, cyc, nmisa, nmst, md, sd);
        chk("mcyc_hi_illegal", il, 1'b1);
`endif

        // Random operations against the reference model.
        for (int n = 0; n < 80; n++) begin
            logic [2:0] f3;
            logic [11:0] a;
            logic [4:0] r1;
            logic [31:0] rv;
            int sel;
            @(negedge CLK);
            misa_MXL_i = 2'($urandom_range(3, 0));
            misa_ext_i = 26'($urandom);
            mvendorid_i = $urandom; marchid_i = $urandom; mimpid_i = $urandom;
            mhartid_i = $urandom; mstatus_i = $urandom;
            f3 = 3'($urandom_range(7, 0));
            r1 = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom);
            rv = $urandom;
            sel = $urandom_range(9, 0);
            case (sel)
                0: a = 12'h300; 1: a = 12'h301; 2: a = 12'h340; 3: a = 12'h340;
                4: a = 12'hF11; 5: a = 12'hF12; 6: a = 12'hF13; 7: a = 12'hF14;
                8: a = ($urandom_range(1, 0) == 0) ? 12'hB00 : 12'hB80;
                default: a = 12'($urandom);
            endcase
`ifdef CSR_MCYCLE_EN
            if (a == 12'hB00 || a == 12'hB80) a = 12'h340;
`endif
            model(f3, a, r1, rv, e_rd, e_il, e_cyc, tgt, nv);
            do_op($sformatf("rnd%0d", n), f3, a, r1, rv, $urandom_range(2, 0),
                  rd, il, cyc, nmisa, nmst, md, sd);
            chk($sformatf("rnd%0d_rdata", n), rd, e_rd);
            chk($sformatf("rnd%0d_illegal", n), il, e_il);
            chk($sformatf("rnd%0d_latency", n), cyc, e_cyc);
            chk($sformatf("rnd%0d_misa_en", n), nmisa, (tgt == 1) ? 1 : 0);
            chk($sformatf("rnd%0d_mstatus_en", n), nmst, (tgt == 2) ? 1 : 0);
            if (tgt == 1) chk($sformatf("rnd%0d_misa_d", n), md, repack(nv));
            if (tgt == 2) chk($sformatf("rnd%0d_mstatus_d", n), sd, nv);
            if (tgt == 3) mscratch_m = nv;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
